// File: rtl/btn_debounce_if.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce_if
//  Description : Signal bundle between a raw push-button source and the
//                btn_debounce block.
//                  btn_in      raw, asynchronous, bouncy button level
//                  btn_level   debounced level (1 = pressed)
//                  btn_press   one-cycle strobe on an accepted press / repeat
//                  btn_release one-cycle strobe on an accepted release
//                master : the side that owns the raw button (drives btn_in)
//                slave  : the debouncer (drives the cleaned outputs)
//  Revision    : 1.0  initial release
// ============================================================================
interface btn_debounce_if;
    logic btn_in;
    logic btn_level;
    logic btn_press;
    logic btn_release;

    modport master (
        output btn_in,
        input  btn_level,
        input  btn_press,
        input  btn_release
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output btn_press,
        output btn_release
    );
endinterface
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : Cleans a raw asynchronous push-button ahead of the LED
//                counter stage. A 2-flop synchroniser feeds a 4-state
//                stability-counter FSM that produces a registered debounced
//                level plus one-cycle press / release strobes.
//  Ports       : clk   in  system clock
//                rst   in  synchronous active-high reset
//                btn   slave modport of btn_debounce_if
//                      (btn_in in; btn_level, btn_press, btn_release out)
//  Config      : `define AUTOREPEAT_EN to add hold-to-repeat btn_press
//                pulses (REPEAT_DELAY cycles after the accepted press, then
//                every REPEAT_RATE cycles). Default build: one btn_press per
//                accepted press, REP_* parameters unused by the datapath.
//  Revision    : 1.0  initial release
// ============================================================================
module btn_debounce #(
    parameter int unsigned DB_WIDTH     = 22,
    parameter int unsigned DB_MAX       = 2_500_000,
    parameter int unsigned REP_WIDTH    = 24,
    parameter int unsigned REPEAT_DELAY = 10_000_000,
    parameter int unsigned REPEAT_RATE  = 2_500_000
) (
    input  logic          clk,
    input  logic          rst,
    btn_debounce_if.slave btn
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------------
    if (DB_MAX < 2) begin : g_chk_db_max
        $error("btn_debounce: DB_MAX must be at least 2");
    end

    if (((DB_MAX - 1) >> DB_WIDTH) != 0) begin : g_chk_db_width
        $error("btn_debounce: DB_WIDTH too narrow to hold DB_MAX-1");
    end

    if ((REPEAT_DELAY < 1) || (REPEAT_RATE < 1)) begin : g_chk_rep_min
        $error("btn_debounce: REPEAT_DELAY and REPEAT_RATE must be non-zero");
    end

    if ((((REPEAT_DELAY - 1) >> REP_WIDTH) != 0) ||
        (((REPEAT_RATE - 1) >> REP_WIDTH) != 0)) begin : g_chk_rep_width
        $error("btn_debounce: REP_WIDTH too narrow for the repeat intervals");
    end

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_IDLE      = 2'd0;  // stable released
    localparam logic [1:0] c_CHK_PRESS = 2'd1;  // qualifying a press
    localparam logic [1:0] c_PRESSED   = 2'd2;  // stable pressed
    localparam logic [1:0] c_CHK_REL   = 2'd3;  // qualifying a release

    localparam logic [DB_WIDTH-1:0] c_DB_LAST = DB_WIDTH'(DB_MAX - 1);
    localparam logic [DB_WIDTH-1:0] c_DB_ONE  = DB_WIDTH'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic                r_sync1;
    logic                r_sync2;
    logic [1:0]          r_state;
    logic [DB_WIDTH-1:0] r_cnt;
    logic                r_level;
    logic                r_press;
    logic                r_release;

    // Stability counter has reached its terminal value; only meaningful in
    // the two CHK states.
    logic w_db_done;
    assign w_db_done = (r_cnt == c_DB_LAST);

    // ------------------------------------------------------------------------
    // Two-flop synchroniser. Only r_sync2 is allowed to reach the FSM.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn.btn_in;
            r_sync2 <= r_sync1;
        end
    end

`ifdef AUTOREPEAT_EN
    // ------------------------------------------------------------------------
    // Auto-repeat. The counter measures time spent stably in PRESSED since
    // the most recent entry into PRESSED. r_rep_first selects the long
    // initial delay until the first repeat has fired, then the shorter rate.
    // While qualifying a release the counter holds its value; a bounce back
    // into PRESSED re-enters PRESSED and therefore starts timing afresh.
    // ------------------------------------------------------------------------
    localparam logic [REP_WIDTH-1:0] c_REP_DELAY_LAST = REP_WIDTH'(REPEAT_DELAY - 1);
    localparam logic [REP_WIDTH-1:0] c_REP_RATE_LAST  = REP_WIDTH'(REPEAT_RATE - 1);
    localparam logic [REP_WIDTH-1:0] c_REP_ONE        = REP_WIDTH'(1);

    logic [REP_WIDTH-1:0] r_rep_cnt;
    logic                 r_rep_first;
    logic                 w_enter_pressed;
    logic                 w_hold_pressed;
    logic                 w_rep_fire;

    assign w_enter_pressed = ((r_state == c_CHK_PRESS) && r_sync2 && w_db_done) ||
                             ((r_state == c_CHK_REL)   && r_sync2);
    assign w_hold_pressed  = (r_state == c_PRESSED) && r_sync2;
    assign w_rep_fire      = w_hold_pressed &&
                             (r_rep_cnt == (r_rep_first ? c_REP_DELAY_LAST
                                                        : c_REP_RATE_LAST));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
        end else if (w_enter_pressed) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b1;
        end else if (w_rep_fire) begin
            r_rep_cnt   <= '0;
            r_rep_first <= 1'b0;
        end else if (w_hold_pressed) begin
            r_rep_cnt   <= r_rep_cnt + c_REP_ONE;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Debounce FSM. The strobes default low every cycle so that each event
    // produces exactly one cycle of btn_press or btn_release. Press and
    // release are raised from mutually exclusive states, so they can never
    // be high together.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    if (r_sync2) begin
                        r_state <= c_CHK_PRESS;
                        r_cnt   <= '0;
                    end
                end

                c_CHK_PRESS: begin
                    if (!r_sync2) begin
                        // Bounce: discard the partial count, no pulse.
                        r_state <= c_IDLE;
                    end else if (w_db_done) begin
                        r_state <= c_PRESSED;
                        r_level <= 1'b1;
                        r_press <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + c_DB_ONE;
                    end
                end

                c_PRESSED: begin
                    if (!r_sync2) begin
                        r_state <= c_CHK_REL;
                        r_cnt   <= '0;
                    end
`ifdef AUTOREPEAT_EN
                    else if (w_rep_fire) begin
                        r_press <= 1'b1;
                    end
`endif
                end

                c_CHK_REL: begin
                    if (r_sync2) begin
                        // Bounce: still pressed, no pulse.
                        r_state   <= c_PRESSED;
                    end else if (w_db_done) begin
                        r_state   <= c_IDLE;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                    end else begin
                        r_cnt     <= r_cnt + c_DB_ONE;
                    end
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (all registered)
    // ------------------------------------------------------------------------
    assign btn.btn_level   = r_level;
    assign btn.btn_press   = r_press;
    assign btn.btn_release = r_release;

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btn_debounce
//  Description : Self-checking bench for btn_debounce (DB_MAX=4, DB_WIDTH=3).
//                A run-length reference model predicts the outputs; a single
//                stimulus process compares every cycle and also checks
//                hand-computed event counts and latencies.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_btn_debounce;

    localparam int DB_MAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    btn_debounce_if bif();

    btn_debounce #(
        .DB_WIDTH     (3),
        .DB_MAX       (DB_MAX),
        .REP_WIDTH    (4),
        .REPEAT_DELAY (8),
        .REPEAT_RATE  (3)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .btn (bif)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model. The debounced level flips once DB_MAX+1 consecutive
    // synchronised samples disagree with it; any agreeing sample, or a flip,
    // restarts the run. The synchroniser is modelled as a 2-deep delay line.
    // ------------------------------------------------------------------------
    int   cyc = 0;
    logic m_d1 = 1'b0, m_d2 = 1'b0;
    logic m_level = 1'b0, m_press = 1'b0, m_rel = 1'b0;
    int   m_run = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_d1    <= 1'b0;
            m_d2    <= 1'b0;
            m_level <= 1'b0;
            m_press <= 1'b0;
            m_rel   <= 1'b0;
            m_run   <= 0;
        end else begin
            m_d1    <= bif.btn_in;
            m_d2    <= m_d1;
            m_press <= 1'b0;
            m_rel   <= 1'b0;
            if (m_d2 == m_level) begin
                m_run <= 0;
            end else if (m_run == DB_MAX) begin
                // this sample is the (DB_MAX+1)-th consecutive disagreement
                m_run   <= 0;
                m_level <= m_d2;
                m_press <= m_d2;
                m_rel   <= ~m_d2;
            end else begin
                m_run <= m_run + 1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------------
    int tests = 0;
    int fails = 0;
    int npress = 0, nrel = 0;
    int last_press = -1, last_rel = -1;
    int c0 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one clock, then compare the DUT against the model.
    task automatic tick();
        @(posedge clk);
        #1;
        check("level_vs_model",   32'(bif.btn_level),   32'(m_level));
        check("press_vs_model",   32'(bif.btn_press),   32'(m_press));
        check("release_vs_model", 32'(bif.btn_release), 32'(m_rel));
        check("press_release_excl", 32'(bif.btn_press & bif.btn_release), 32'd0);
        if (bif.btn_press === 1'b1) begin
            npress++;
            last_press = cyc;
        end
        if (bif.btn_release === 1'b1) begin
            nrel++;
            last_rel = cyc;
        end
    endtask

    task automatic clear_counts();
        npress     = 0;
        nrel       = 0;
        last_press = -1;
        last_rel   = -1;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        bif.btn_in = 1'b0;
        rst        = 1'b1;
        tick();
        tick();

        // 1. Button held during reset: everything stays 0.
        bif.btn_in = 1'b1;
        repeat (3) begin
            tick();
            check("rst_level",   32'(bif.btn_level),   32'd0);
            check("rst_press",   32'(bif.btn_press),   32'd0);
            check("rst_release", 32'(bif.btn_release), 32'd0);
        end
        bif.btn_in = 1'b0;
        tick();
        rst = 1'b0;
        repeat (5) tick();

        // 2. Clean press: pulse on edge 6 after the first sampling edge.
        clear_counts();
        bif.btn_in = 1'b1;
        c0 = cyc + 1;
        repeat (20) tick();
        check("press_count",       32'(npress),          32'd1);
        check("press_latency",     32'(last_press - c0), 32'd6);
        check("press_level",       32'(bif.btn_level),   32'd1);
        check("press_no_release",  32'(nrel),            32'd0);

        // 4. Clean release: symmetric latency, no press.
        clear_counts();
        bif.btn_in = 1'b0;
        c0 = cyc + 1;
        repeat (20) tick();
        check("release_count",     32'(nrel),            32'd1);
        check("release_latency",   32'(last_rel - c0),   32'd6);
        check("release_level",     32'(bif.btn_level),   32'd0);
        check("release_no_press",  32'(npress),          32'd0);

        // 3. Bounce 1,0,1,0 (2 cycles each), then held: one press, timed
        //    from the final rising sample.
        clear_counts();
        for (int i = 0; i < 4; i++) begin
            bif.btn_in = (i % 2 == 0) ? 1'b1 : 1'b0;
            repeat (2) tick();
        end
        bif.btn_in = 1'b1;
        c0 = cyc + 1;
        repeat (20) tick();
        check("bounce_press_count",   32'(npress),          32'd1);
        check("bounce_press_latency", 32'(last_press - c0), 32'd6);
        check("bounce_no_release",    32'(nrel),            32'd0);

        // 5. Single-cycle low glitch while pressed: nothing happens.
        clear_counts();
        bif.btn_in = 1'b0;
        tick();
        bif.btn_in = 1'b1;
        repeat (10) tick();
        check("glitch_level",      32'(bif.btn_level), 32'd1);
        check("glitch_no_press",   32'(npress),        32'd0);
        check("glitch_no_release", 32'(nrel),          32'd0);

        // Low for DB_MAX cycles: one sample short of a release.
        clear_counts();
        bif.btn_in = 1'b0;
        repeat (DB_MAX) tick();
        bif.btn_in = 1'b1;
        repeat (10) tick();
        check("short_low_level",      32'(bif.btn_level), 32'd1);
        check("short_low_no_release", 32'(nrel),          32'd0);

        // 6. Reset while pressed: outputs drop, no release, then re-qualify.
        clear_counts();
        rst = 1'b1;
        tick();
        check("midrst_level", 32'(bif.btn_level), 32'd0);
        tick();
        rst = 1'b0;
        c0 = cyc + 1;
        repeat (20) tick();
        check("midrst_no_release",   32'(nrel),            32'd0);
        check("midrst_press_count",  32'(npress),          32'd1);
        check("midrst_press_latency", 32'(last_press - c0), 32'd6);
        check("midrst_level_after",  32'(bif.btn_level),   32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
